// File: rtl/audio_mix_pkg.sv
// audio_mix_out shared types and constants.
// FSM states, accumulator sizing and clip counter width.
package audio_mix_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SAT   = 2'd2,
      WRITE = 2'd3
   } state_e;

   localparam int CLIP_W = 16;

   // Guard bits so NUM_SRC terms plus the mic sample never overflow.
   function automatic int acc_width(input int dw, input int ns);
      return dw + $clog2(ns + 1) + 1;
   endfunction

endpackage

// File: rtl/audio_mix_out_if.sv
// Audio_Controller FIFO handshake and sample bus.
// master = controller side, slave = mixer side.
interface audio_mix_out_if #(
   parameter int DATA_W = 32
);

   logic              audio_in_available;
   logic              audio_out_allowed;
   logic [DATA_W-1:0] left_channel_audio_in;
   logic [DATA_W-1:0] right_channel_audio_in;
   logic              read_audio_in;
   logic [DATA_W-1:0] left_channel_audio_out;
   logic [DATA_W-1:0] right_channel_audio_out;
   logic              write_audio_out;

   modport master (
      output audio_in_available,
      output audio_out_allowed,
      output left_channel_audio_in,
      output right_channel_audio_in,
      input  read_audio_in,
      input  left_channel_audio_out,
      input  right_channel_audio_out,
      input  write_audio_out
   );

   modport slave (
      input  audio_in_available,
      input  audio_out_allowed,
      input  left_channel_audio_in,
      input  right_channel_audio_in,
      output read_audio_in,
      output left_channel_audio_out,
      output right_channel_audio_out,
      output write_audio_out
   );

endinterface

// File: rtl/audio_mix_out_sat_clip.sv
// Signed clamp from the wide accumulator down to the sample width.
// clip_o flags that the value was outside the sample range.
module sat_clip #(
   parameter int ACC_W  = 36,
   parameter int DATA_W = 32
) (
   input  logic [ACC_W-1:0]  acc_i,
   output logic [DATA_W-1:0] sat_o,
   output logic              clip_o
);

   logic [ACC_W-DATA_W:0] hi;

   // In range only when all bits above the sample sign bit match it.
   always_comb begin
      hi     = acc_i[ACC_W-1:DATA_W-1];
      clip_o = !((&hi) || (~|hi));
      sat_o  = acc_i[DATA_W-1:0];
      if (clip_o) begin
         if (acc_i[ACC_W-1]) begin
            sat_o = {1'b1, {(DATA_W-1){1'b0}}};
         end else begin
            sat_o = {1'b0, {(DATA_W-1){1'b1}}};
         end
      end
   end

endmodule

// File: rtl/audio_mix_out.sv
// Mixes the mic sample with NUM_SRC gained/muted tone sources,
// saturates the result and counts clipped frames.
module audio_mix_out
   import audio_mix_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NUM_SRC = 4,
   parameter int GAIN_W  = 3
) (
   input  logic                      CLOCK_50,
   input  logic                      reset,
   audio_mix_out_if.slave            aud,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [NUM_SRC*GAIN_W-1:0] src_shift,
   input  logic [NUM_SRC-1:0]        src_mute,
   input  logic                      mic_en,
   output logic [DATA_W-1:0]         tap_data,
   output logic                      tap_valid,
   output logic [CLIP_W-1:0]         clip_count,
   output logic                      busy
);

   localparam int ACC_W = acc_width(DATA_W, NUM_SRC);
   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int EXT_W = ACC_W - DATA_W;

   state_e                    state_q;
   logic [IDX_W-1:0]          idx_q;
   logic signed [ACC_W-1:0]   acc_l_q;
   logic signed [ACC_W-1:0]   acc_r_q;
   logic [NUM_SRC*DATA_W-1:0] src_q;
   logic [NUM_SRC*GAIN_W-1:0] shift_q;
   logic [NUM_SRC-1:0]        mute_q;
   logic [DATA_W-1:0]         tap_cap_q;
   logic [DATA_W-1:0]         out_l_q;
   logic [DATA_W-1:0]         out_r_q;
   logic [DATA_W-1:0]         tap_q;
   logic                      read_q;
   logic                      write_q;
   logic                      tap_vld_q;
   logic [CLIP_W-1:0]         clip_q;

   logic signed [DATA_W-1:0]  sk;
   logic signed [DATA_W-1:0]  shf;
   logic [GAIN_W-1:0]         sh;
   logic                      mt;
   logic signed [ACC_W-1:0]   term_d;
   logic [DATA_W-1:0]         sat_l_d;
   logic [DATA_W-1:0]         sat_r_d;
   logic                      clip_l_d;
   logic                      clip_r_d;
   logic                      go;

   assign go = aud.audio_in_available && aud.audio_out_allowed;

   // Select the current source from the snapshot and form its gained term.
   always_comb begin
      sk = '0;
      sh = '0;
      mt = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (idx_q == IDX_W'(k)) begin
            sk = src_q[k*DATA_W +: DATA_W];
            sh = shift_q[k*GAIN_W +: GAIN_W];
            mt = mute_q[k];
         end
      end
      shf    = sk >>> sh;
      term_d = mt ? '0 : {{EXT_W{shf[DATA_W-1]}}, shf};
   end

   sat_clip #(
      .ACC_W  (ACC_W),
      .DATA_W (DATA_W)
   ) u_sat_l (
      .acc_i  (acc_l_q),
      .sat_o  (sat_l_d),
      .clip_o (clip_l_d)
   );

   sat_clip #(
      .ACC_W  (ACC_W),
      .DATA_W (DATA_W)
   ) u_sat_r (
      .acc_i  (acc_r_q),
      .sat_o  (sat_r_d),
      .clip_o (clip_r_d)
   );

   // Frame FSM: pop, accumulate one source per cycle, clamp, push.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         acc_l_q   <= '0;
         acc_r_q   <= '0;
         src_q     <= '0;
         shift_q   <= '0;
         mute_q    <= '0;
         tap_cap_q <= '0;
         out_l_q   <= '0;
         out_r_q   <= '0;
         tap_q     <= '0;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         tap_vld_q <= 1'b0;
         clip_q    <= '0;
      end else begin
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         tap_vld_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (go) begin
                  read_q    <= 1'b1;
                  acc_l_q   <= mic_en ?
                     {{EXT_W{aud.left_channel_audio_in[DATA_W-1]}},
                      aud.left_channel_audio_in} : '0;
                  acc_r_q   <= mic_en ?
                     {{EXT_W{aud.right_channel_audio_in[DATA_W-1]}},
                      aud.right_channel_audio_in} : '0;
                  src_q     <= src_data;
                  shift_q   <= src_shift;
                  mute_q    <= src_mute;
                  tap_cap_q <= aud.left_channel_audio_in;
                  idx_q     <= '0;
                  state_q   <= ACCUM;
               end
            end
            ACCUM: begin
               acc_l_q <= acc_l_q + term_d;
               acc_r_q <= acc_r_q + term_d;
               if (idx_q == IDX_W'(NUM_SRC - 1)) begin
                  state_q <= SAT;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            SAT: begin
               out_l_q <= sat_l_d;
               out_r_q <= sat_r_d;
               if ((clip_l_d || clip_r_d) && (clip_q != '1)) begin
                  clip_q <= clip_q + 1'b1;
               end
               state_q <= WRITE;
            end
            WRITE: begin
               if (aud.audio_out_allowed) begin
                  write_q   <= 1'b1;
                  tap_vld_q <= 1'b1;
                  tap_q     <= tap_cap_q;
                  state_q   <= IDLE;
               end
            end
         endcase
      end
   end

   assign aud.read_audio_in           = read_q;
   assign aud.write_audio_out         = write_q;
   assign aud.left_channel_audio_out  = out_l_q;
   assign aud.right_channel_audio_out = out_r_q;
   assign tap_data                    = tap_q;
   assign tap_valid                   = tap_vld_q;
   assign clip_count                  = clip_q;
   assign busy                        = (state_q != IDLE);

endmodule

// File: tb/tb_audio_mix_out.sv
// Scoreboard bench for audio_mix_out (DATA_W=32, NUM_SRC=4).
module tb_audio_mix_out;

   localparam int DW = 32;
   localparam int NS = 4;
   localparam int GW = 3;
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   typedef struct {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
      logic [DW-1:0] tap;
   } exp_t;

   logic             clk;
   logic             reset;
   logic [NS*DW-1:0] src_data;
   logic [NS*GW-1:0] src_shift;
   logic [NS-1:0]    src_mute;
   logic             mic_en;
   logic [DW-1:0]    tap_data;
   logic             tap_valid;
   logic [15:0]      clip_count;
   logic             busy;

   exp_t exp_q[$];
   int   checks;
   int   errors;
   int   exp_clip;

   audio_mix_out_if #(.DATA_W(DW)) aud ();

   audio_mix_out #(
      .DATA_W  (DW),
      .NUM_SRC (NS),
      .GAIN_W  (GW)
   ) dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .aud        (aud),
      .src_data   (src_data),
      .src_shift  (src_shift),
      .src_mute   (src_mute),
      .mic_en     (mic_en),
      .tap_data   (tap_data),
      .tap_valid  (tap_valid),
      .clip_count (clip_count),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mix_ch(
      input  logic             mic,
      input  logic [DW-1:0]    x,
      input  logic [NS*DW-1:0] sd,
      input  logic [NS*GW-1:0] ss,
      input  logic [NS-1:0]    sm,
      output logic             clp
   );
      longint acc;
      logic signed [DW-1:0] t;
      logic [DW-1:0] s;
      logic [GW-1:0] g;
      acc = 0;
      if (mic) begin
         t = $signed(x);
         acc = t;
      end
      for (int k = 0; k < NS; k++) begin
         if (!sm[k]) begin
            s = sd[k*DW +: DW];
            g = ss[k*GW +: GW];
            t = $signed(s) >>> g;
            acc = acc + t;
         end
      end
      clp = 1'b0;
      if (acc > MAXV) begin
         clp = 1'b1;
         acc = MAXV;
      end else if (acc < MINV) begin
         clp = 1'b1;
         acc = MINV;
      end
      return acc[DW-1:0];
   endfunction

   task automatic push_exp(
      input logic mic, input logic [DW-1:0] l, input logic [DW-1:0] r,
      input logic [NS*DW-1:0] sd, input logic [NS*GW-1:0] ss,
      input logic [NS-1:0] sm
   );
      exp_t e;
      logic cl, cr;
      e.l   = mix_ch(mic, l, sd, ss, sm, cl);
      e.r   = mix_ch(mic, r, sd, ss, sm, cr);
      e.tap = l;
      exp_q.push_back(e);
      if ((cl || cr) && exp_clip < 16'hFFFF) exp_clip++;
   endtask

   task automatic drive(
      input logic mic, input logic [DW-1:0] l, input logic [DW-1:0] r,
      input logic [NS*DW-1:0] sd, input logic [NS*GW-1:0] ss,
      input logic [NS-1:0] sm
   );
      mic_en = mic;
      aud.left_channel_audio_in  = l;
      aud.right_channel_audio_in = r;
      src_data  = sd;
      src_shift = ss;
      src_mute  = sm;
      aud.audio_in_available = 1'b1;
      aud.audio_out_allowed  = 1'b1;
   endtask

   task automatic wait_read(input string nm);
      bit got;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (aud.read_audio_in === 1'b1) got = 1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s pop: read_audio_in never seen, need 1", nm);
      end
   endtask

   task automatic check_out(input string nm);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: empty queue at write", nm);
         return;
      end
      e = exp_q.pop_front();
      checks++;
      if (aud.left_channel_audio_out !== e.l) begin
         errors++;
         $display("FAIL %s left: got %h need %h", nm,
                  aud.left_channel_audio_out, e.l);
      end
      checks++;
      if (aud.right_channel_audio_out !== e.r) begin
         errors++;
         $display("FAIL %s right: got %h need %h", nm,
                  aud.right_channel_audio_out, e.r);
      end
      checks++;
      if (tap_data !== e.tap || tap_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s tap: got %h/%b need %h/1", nm,
                  tap_data, tap_valid, e.tap);
      end
      checks++;
      if (clip_count !== 16'(exp_clip)) begin
         errors++;
         $display("FAIL %s clip_count: got %0d need %0d", nm,
                  clip_count, exp_clip);
      end
   endtask

   task automatic run_frame(
      input string nm,
      input logic mic, input logic [DW-1:0] l, input logic [DW-1:0] r,
      input logic [NS*DW-1:0] sd, input logic [NS*GW-1:0] ss,
      input logic [NS-1:0] sm,
      input bit chg, input logic [NS*DW-1:0] new_sd
   );
      int n;
      bit got;
      @(negedge clk);
      drive(mic, l, r, sd, ss, sm);
      push_exp(mic, l, r, sd, ss, sm);
      wait_read(nm);
      aud.audio_in_available = 1'b0;
      if (chg) src_data = new_sd;
      n = 0;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         n++;
         if (aud.write_audio_out === 1'b1) got = 1;
      end
      checks++;
      if (!got || n != NS + 2) begin
         errors++;
         $display("FAIL %s latency: got %0d (seen %0b) need %0d",
                  nm, n, got, NS + 2);
      end
      check_out(nm);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (aud.left_channel_audio_out !== '0 ||
          aud.right_channel_audio_out !== '0 || tap_data !== '0) begin
         errors++;
         $display("FAIL reset data: got %h %h %h need 0",
                  aud.left_channel_audio_out,
                  aud.right_channel_audio_out, tap_data);
      end
      checks++;
      if (aud.read_audio_in !== 1'b0 || aud.write_audio_out !== 1'b0 ||
          tap_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset strobes: rd %b wr %b tv %b busy %b need 0",
                  aud.read_audio_in, aud.write_audio_out,
                  tap_valid, busy);
      end
      checks++;
      if (clip_count !== 16'h0) begin
         errors++;
         $display("FAIL reset clip: got %0d need 0", clip_count);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      run_frame("basic", 1'b1, 32'h00001000, 32'hFFFFF000,
                {96'h0, 32'h100}, 12'h0, 4'b1110, 1'b0, '0);
      checks++;
      if (aud.left_channel_audio_out !== 32'h00001100 ||
          aud.right_channel_audio_out !== 32'hFFFFF100) begin
         errors++;
         $display("FAIL basic const: got %h %h need 00001100 fffff100",
                  aud.left_channel_audio_out,
                  aud.right_channel_audio_out);
      end
   endtask

   task automatic test_saturation();
      run_frame("sat_pos", 1'b1, 32'h7FFFFFF0, 32'h0,
                {96'h0, 32'h100}, 12'h0, 4'b1110, 1'b0, '0);
      checks++;
      if (aud.left_channel_audio_out !== 32'h7FFFFFFF) begin
         errors++;
         $display("FAIL sat_pos const: got %h need 7fffffff",
                  aud.left_channel_audio_out);
      end
      run_frame("sat_neg", 1'b1, 32'h80000010, 32'h0,
                {96'h0, 32'hFFFFFF00}, 12'h0, 4'b1110, 1'b0, '0);
      checks++;
      if (aud.left_channel_audio_out !== 32'h80000000 ||
          clip_count !== 16'd2) begin
         errors++;
         $display("FAIL sat_neg const: got %h clip %0d need 80000000 clip 2",
                  aud.left_channel_audio_out, clip_count);
      end
   endtask

   task automatic test_gain();
      logic [NS*DW-1:0] sd;
      logic [NS*GW-1:0] ss;
      sd = {32'h0, 32'hFFFFFC00, 32'h400, 32'h0};
      ss = {3'd0, 3'd2, 3'd2, 3'd0};
      run_frame("gain_cancel", 1'b0, 32'h12345678, 32'h9ABCDEF0,
                sd, ss, 4'b1001, 1'b0, '0);
      run_frame("gain_one", 1'b0, 32'h12345678, 32'h9ABCDEF0,
                sd, ss, 4'b1101, 1'b0, '0);
      checks++;
      if (aud.right_channel_audio_out !== 32'h00000100) begin
         errors++;
         $display("FAIL gain_one const: got %h need 00000100",
                  aud.right_channel_audio_out);
      end
   endtask

   task automatic test_snapshot();
      run_frame("snap_old", 1'b1, 32'h10, 32'h20,
                {96'h0, 32'h100}, 12'h0, 4'b1110,
                1'b1, {96'h0, 32'h200});
      run_frame("snap_new", 1'b1, 32'h10, 32'h20,
                {96'h0, 32'h200}, 12'h0, 4'b1110, 1'b0, '0);
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] hl, hr;
      @(negedge clk);
      drive(1'b1, 32'h5, 32'h7, {96'h0, 32'h1}, 12'h0, 4'b1110);
      push_exp(1'b1, 32'h5, 32'h7, {96'h0, 32'h1}, 12'h0, 4'b1110);
      wait_read("bp");
      aud.audio_out_allowed = 1'b0;
      repeat (NS + 1) @(negedge clk);
      hl = aud.left_channel_audio_out;
      hr = aud.right_channel_audio_out;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b1 || aud.write_audio_out !== 1'b0 ||
             aud.read_audio_in !== 1'b0 ||
             aud.left_channel_audio_out !== hl ||
             aud.right_channel_audio_out !== hr) begin
            errors++;
            $display("FAIL bp stall %0d: busy %b wr %b rd %b out %h %h",
                     i, busy, aud.write_audio_out, aud.read_audio_in,
                     aud.left_channel_audio_out,
                     aud.right_channel_audio_out);
         end
      end
      aud.audio_out_allowed  = 1'b1;
      aud.audio_in_available = 1'b0;
      @(negedge clk);
      checks++;
      if (aud.write_audio_out !== 1'b1) begin
         errors++;
         $display("FAIL bp release: write got %b need 1",
                  aud.write_audio_out);
      end
      check_out("bp");
      @(negedge clk);
      checks++;
      if (aud.write_audio_out !== 1'b0 || tap_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp single: write %b tap_valid %b need 0 0",
                  aud.write_audio_out, tap_valid);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      drive(1'b1, 32'h7FFFFFFF, 32'h1, {96'h0, 32'h7FFFFFFF},
            12'h0, 4'b1110);
      wait_read("rst_mid");
      aud.audio_in_available = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_clip = 0;
      checks++;
      if (busy !== 1'b0 || clip_count !== 16'h0 ||
          aud.left_channel_audio_out !== '0 ||
          aud.right_channel_audio_out !== '0 || tap_data !== '0) begin
         errors++;
         $display("FAIL rst_mid state: busy %b clip %0d out %h %h tap %h",
                  busy, clip_count, aud.left_channel_audio_out,
                  aud.right_channel_audio_out, tap_data);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (aud.write_audio_out !== 1'b0 || tap_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid pulse %0d: write %b tap_valid %b need 0",
                     i, aud.write_audio_out, tap_valid);
         end
      end
      run_frame("after_rst", 1'b1, 32'hFFFFFFFE, 32'h3,
                {32'h40, 32'h0, 32'h0, 32'h80}, {3'd6, 3'd0, 3'd0, 3'd1},
                4'b0110, 1'b0, '0);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      exp_clip = 0;
      reset    = 1'b1;
      mic_en   = 1'b0;
      src_data  = '0;
      src_shift = '0;
      src_mute  = '0;
      aud.audio_in_available     = 1'b0;
      aud.audio_out_allowed      = 1'b0;
      aud.left_channel_audio_in  = '0;
      aud.right_channel_audio_in = '0;
      test_reset();
      test_basic();
      test_saturation();
      test_gain();
      test_snapshot();
      test_backpressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/audio_mix_out.md
Name: audio_mix_out

Overview:
- Parametrised successor to the single-tone speaker output stage.
- Sits between the Audio_Controller FIFO handshake and the tone generators (playtone instances).
- Mixes the microphone sample with NUM_SRC tone sources. Each source has a per-source arithmetic-shift gain and a mute bit.
- Replaces wrap-around addition with saturating addition, and counts clip events.
- Exports the unmixed mic sample as a tap for the Filter/tuner path.

Parameters:
- DATA_W, 32: sample width, signed two's complement.
- NUM_SRC, 4: number of tone sources; must be ≥ 1.
- GAIN_W, 3: width of each per-source right-shift amount (0..2^GAIN_W-1).

Ports:
- CLOCK_50  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- audio_in_available  in  1  controller has an input sample ready.
- audio_out_allowed  in  1  controller output FIFO has space.
- left_channel_audio_in  in  DATA_W  mic left sample.
- right_channel_audio_in  in  DATA_W  mic right sample.
- read_audio_in  out  1  one-cycle pop strobe to the controller.
- left_channel_audio_out  out  DATA_W  mixed left sample, registered.
- right_channel_audio_out  out  DATA_W  mixed right sample, registered.
- write_audio_out  out  1  one-cycle push strobe to the controller.
- src_data  in  NUM_SRC*DATA_W  tone samples; source k occupies bits [k*DATA_W +: DATA_W].
- src_shift  in  NUM_SRC*GAIN_W  per-source arithmetic right-shift amount.
- src_mute  in  NUM_SRC  1 means the source contributes 0.
- mic_en  in  1  1 means the mic sample is included in the mix.
- tap_data  out  DATA_W  unmixed left mic sample.
- tap_valid  out  1  one-cycle strobe qualifying tap_data.
- clip_count  out  16  number of saturated output frames.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulators 0; clip_count 0.
- Reset mid-operation aborts the current frame. No write_audio_out or tap_valid pulse is issued for it.
- State machine: IDLE -> ACCUM -> SAT -> WRITE -> IDLE.
- IDLE:
  - Transition when audio_in_available and audio_out_allowed are both 1.
  - In that cycle, pulse read_audio_in for exactly one cycle.
  - Capture the input samples into left/right accumulators: sign-extended if mic_en=1, else 0.
  - Snapshot src_data, src_shift, src_mute, and the raw left input for the tap.
  - Set idx=0 and go to ACCUM.
- ACCUM, one source per cycle:
  - term = mute ? 0 : (src_k >>> shift), an arithmetic shift.
  - Add term to both accumulators, then increment idx.
  - After idx = NUM_SRC-1, go to SAT.
  - The same mono term is added to both channels.
- Accumulator width: ACC_W = DATA_W + clog2(NUM_SRC+1) + 1 guard bits, so no overflow is possible inside the accumulator.
- SAT:
  - Clamp each accumulator to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register the results into the outputs.
  - If either channel clamped, increment clip_count by 1 for the frame. clip_count saturates at 0xFFFF.
  - Go to WRITE.
- WRITE:
  - While audio_out_allowed=0, hold: outputs stable, busy=1, no pulse.
  - When audio_out_allowed=1, pulse write_audio_out and tap_valid for one cycle, with tap_data = captured left input. Go to IDLE.
- Latency: write_audio_out asserts exactly NUM_SRC+2 cycles after read_audio_in when not stalled.
- New samples are never popped while busy. The controller FIFO absorbs the backlog.
- Output and tap registers hold their last values in IDLE.
- src_* input changes after the IDLE snapshot do not affect the frame in flight.

Decomposition:
- Package audio_mix_pkg holds:
  - the state enum (IDLE, ACCUM, SAT, WRITE);
  - the ACC_W computation constant;
  - the clip_count width constant (16).
- One sub-module, sat_clip: a combinational ACC_W -> DATA_W clamp with a clipped flag. It is instantiated once per channel.
- The FSM, index counter and accumulators stay in audio_mix_out.

Test Plan (DATA_W=32, NUM_SRC=4):
- Basic mix:
  - Stimulus: mic_en=1, left_in=0x00001000, right_in=0xFFFFF000, src0=0x100 with shift 0, src1-3 muted.
  - Response: left_out=0x00001100, right_out=0xFFFFF100, write_audio_out exactly 6 cycles after read_audio_in, tap_data=0x00001000.
- Saturation:
  - Stimulus: left_in=0x7FFFFFF0 and src0=+0x100; then left_in=0x80000010 and src0=-0x100.
  - Response: left_out=0x7FFFFFFF, then 0x80000000; clip_count=2.
- Gain and sign:
  - Stimulus: mic_en=0, src1=0x400 with shift 2, src2=0xFFFFFC00 with shift 2, src0/src3 muted.
  - Response: both outputs 0x00000000. Same test with src2 muted: outputs 0x00000100.
- Backpressure:
  - Stimulus: audio_out_allowed forced low for 10 cycles starting in WRITE.
  - Response: busy=1 throughout, outputs stable, exactly one write_audio_out pulse on the first cycle audio_out_allowed=1, no second read_audio_in before IDLE.
- Reset mid-frame:
  - Stimulus: reset asserted for 1 cycle during ACCUM, idx=2.
  - Response: next cycle all outputs 0, busy=0, no write/tap pulse, clip_count=0; the next available sample is processed normally.
- Snapshot:
  - Stimulus: src0 changed from 0x100 to 0x200 during ACCUM.
  - Response: the current frame uses 0x100; the next frame uses 0x200.
